// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and helpers for the SDRAM port-0 arbiter (write FIFO entry, FSM states).
package sdram_port_arbiter_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_GUARD = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } arb_wr_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Port-0 bus between the arbiter (master) and the sdram_burst controller (slave).
interface sdram_port_arbiter_if;
  import sdram_port_arbiter_pkg::*;

  logic [ADDR_W-1:0] sd_addr;
  logic [DATA_W-1:0] sd_data;
  logic              sd_wr_req;
  logic              sd_rd_req;
  logic              sd_end_burst_req;
  logic              sd_ready;
  logic              sd_data_available;
  logic [DATA_W-1:0] sd_q;

  modport master (
    output sd_addr, sd_data, sd_wr_req, sd_rd_req, sd_end_burst_req,
    input  sd_ready, sd_data_available, sd_q
  );

  modport slave (
    input  sd_addr, sd_data, sd_wr_req, sd_rd_req, sd_end_burst_req,
    output sd_ready, sd_data_available, sd_q
  );

endinterface

// File: rtl/arb_write_fifo.sv
// Synchronous write-buffer FIFO of address/data entries with a registered read port.
module arb_write_fifo
  import sdram_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  arb_wr_entry_t push_entry,
  input  logic          pop,
  output arb_wr_entry_t pop_entry,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  arb_wr_entry_t mem_q [DEPTH];
  arb_wr_entry_t rd_entry_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_entry_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        rd_entry_q <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_entry = rd_entry_q;
  assign count     = count_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares sdram_burst port 0 between buffered download writes and video burst reads.
// Optional ARB_STATS_EN adds saturating grant/burst counters.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int HIGH_WATER = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              overflow,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end_burst,
  output logic              rd_data_available,
  output logic [DATA_W-1:0] rd_data,
`ifdef ARB_STATS_EN
  output logic [15:0]       stat_wr_grants,
  output logic [15:0]       stat_rd_bursts,
`endif
  sdram_port_arbiter_if.master sd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  arb_state_t        state_q, state_d;
  logic              rd_pending_q, rd_pending_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] sd_rd_addr_q;
  logic              sel_fifo_q;
  logic              wr_req_q, rd_req_q, end_burst_q;
  logic              overflow_q;
  logic              rd_avail_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              issue_wr, issue_rd, end_burst_d;
  logic              rd_pending_now, wr_high;
  logic [ADDR_W-1:0] rd_addr_now;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  arb_wr_entry_t     fifo_head, push_entry;

  assign push_entry = '{addr: wr_addr, data: wr_data};

  arb_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (wr_valid),
    .push_entry (push_entry),
    .pop        (issue_wr),
    .pop_entry  (fifo_head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // A read request in the current cycle counts as pending so it can issue next cycle.
  assign rd_pending_now = rd_pending_q | rd_req;
  assign rd_addr_now    = rd_req ? rd_addr : rd_addr_q;
  assign wr_high        = (fifo_count >= CW'(HIGH_WATER));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= rd_pending_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (issue_rd) begin
          state_d = ARB_READ;
        end else if (issue_wr) begin
          state_d = ARB_GUARD;
        end
      end
      ARB_READ: begin
        if (rd_end_burst) begin
          state_d = ARB_GUARD;
        end
      end
      ARB_GUARD: state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // High-water writes beat reads; otherwise reads win over a non-empty FIFO.
  always_comb begin
    issue_wr    = 1'b0;
    issue_rd    = 1'b0;
    end_burst_d = 1'b0;
    if (state_q == ARB_IDLE && sd.sd_ready) begin
      if (wr_high) begin
        issue_wr = 1'b1;
      end else if (rd_pending_now) begin
        issue_rd = 1'b1;
      end else if (!fifo_empty) begin
        issue_wr = 1'b1;
      end
    end
    if (state_q == ARB_READ && rd_end_burst) begin
      end_burst_d = 1'b1;
    end
    rd_pending_d = issue_rd ? 1'b0 : rd_pending_now;
    rd_addr_d    = rd_addr_now;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      end_burst_q  <= 1'b0;
      sel_fifo_q   <= 1'b0;
      sd_rd_addr_q <= '0;
      overflow_q   <= 1'b0;
      rd_avail_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      wr_req_q    <= issue_wr;
      rd_req_q    <= issue_rd;
      end_burst_q <= end_burst_d;
      if (issue_wr) begin
        sel_fifo_q <= 1'b1;
      end else if (issue_rd) begin
        sel_fifo_q   <= 1'b0;
        sd_rd_addr_q <= rd_addr_now;
      end
      if (wr_valid && fifo_full) begin
        overflow_q <= 1'b1;
      end
      // Read data is forwarded in every state so trailing beats after end_burst are kept.
      rd_avail_q <= sd.sd_data_available;
      if (sd.sd_data_available) begin
        rd_data_q <= sd.sd_q;
      end
    end
  end

  assign wr_ready             = ~fifo_full;
  assign overflow             = overflow_q;
  assign rd_data_available    = rd_avail_q;
  assign rd_data              = rd_data_q;
  assign sd.sd_addr           = sel_fifo_q ? fifo_head.addr : sd_rd_addr_q;
  assign sd.sd_data           = fifo_head.data;
  assign sd.sd_wr_req         = wr_req_q;
  assign sd.sd_rd_req         = rd_req_q;
  assign sd.sd_end_burst_req  = end_burst_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_wr_q, stat_rd_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      if (wr_req_q) begin
        stat_wr_q <= sat_inc16(stat_wr_q);
      end
      if (rd_req_q) begin
        stat_rd_q <= sat_inc16(stat_rd_q);
      end
    end
  end

  assign stat_wr_grants = stat_wr_q;
  assign stat_rd_bursts = stat_rd_q;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: vector table, request scoreboard and corner sequences.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic [24:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        overflow;
  logic        rd_req;
  logic [24:0] rd_addr;
  logic        rd_end_burst;
  logic        rd_data_available;
  logic [15:0] rd_data;
`ifdef ARB_STATS_EN
  logic [15:0] stat_wr_grants;
  logic [15:0] stat_rd_bursts;
`endif

  sdram_port_arbiter_if sd_bus ();

  sdram_port_arbiter #(.FIFO_DEPTH(8), .HIGH_WATER(6)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .wr_valid          (wr_valid),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_ready          (wr_ready),
    .overflow          (overflow),
    .rd_req            (rd_req),
    .rd_addr           (rd_addr),
    .rd_end_burst      (rd_end_burst),
    .rd_data_available (rd_data_available),
    .rd_data           (rd_data),
`ifdef ARB_STATS_EN
    .stat_wr_grants    (stat_wr_grants),
    .stat_rd_bursts    (stat_rd_bursts),
`endif
    .sd                (sd_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_rd;
    logic [24:0] addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [24:0] addr;
    logic [15:0] data;
    logic [24:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  exp_t        expq[$];
  logic [15:0] rdq[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_req_cyc = -10;
  int n_end = 0, n_wr_seen = 0, n_rd_seen = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [24:0] a, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_rd_req(input logic [24:0] a);
    rd_req  = 1'b1;
    rd_addr = a;
    step();
    rd_req  = 1'b0;
  endtask

  task automatic end_burst();
    rd_end_burst = 1'b1;
    step();
    rd_end_burst = 1'b0;
  endtask

  task automatic wait_q(input int target, input int budget, input string name);
    int i = 0;
    while (expq.size() > target && i < budget) begin
      step();
      i++;
    end
    chk(name, 64'(expq.size()), 64'(target));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard: every port-0 request is matched against the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sd_bus.sd_end_burst_req === 1'b1) n_end++;
      if (reset_n === 1'b1) begin
        if (sd_bus.sd_wr_req || sd_bus.sd_rd_req || sd_bus.sd_end_burst_req) begin
          chk("req_spacing", ((cyc - last_req_cyc) >= 2) ? 64'd1 : 64'd0, 64'd1);
          last_req_cyc = cyc;
        end
        if (sd_bus.sd_wr_req || sd_bus.sd_rd_req) begin
          if (sd_bus.sd_wr_req) n_wr_seen++;
          if (sd_bus.sd_rd_req) n_rd_seen++;
          chk("req_onehot", 64'(sd_bus.sd_wr_req & sd_bus.sd_rd_req), 64'd0);
          if (expq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_req: got wr=%0d rd=%0d addr=0x%0h, expected none",
                     sd_bus.sd_wr_req, sd_bus.sd_rd_req, sd_bus.sd_addr);
          end else begin
            e = expq.pop_front();
            $display("req: wr=%0d rd=%0d addr=0x%0h data=0x%0h", sd_bus.sd_wr_req,
                     sd_bus.sd_rd_req, sd_bus.sd_addr, sd_bus.sd_data);
            chk("req_kind", 64'(sd_bus.sd_rd_req), 64'(e.is_rd));
            chk("req_addr", 64'(sd_bus.sd_addr), 64'(e.addr));
            if (!e.is_rd) chk("req_data", 64'(sd_bus.sd_data), 64'(e.data));
          end
        end
        if (rd_data_available) begin
          if (rdq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rd_data: got 0x%0h, expected no beat", rd_data);
          end else begin
            chk("rd_data", 64'(rd_data), 64'(rdq.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    vec_t        vecs[4];
    logic [15:0] beats[4];
    int          end_before;

    vecs[0] = '{25'h0000010, 16'hBEEF, 25'h0000010, 16'hBEEF};
    vecs[1] = '{25'h0000000, 16'h0000, 25'h0000000, 16'h0000};
    vecs[2] = '{25'h1FFFFFF, 16'hFFFF, 25'h1FFFFFF, 16'hFFFF};
    vecs[3] = '{25'h0AAAAAA, 16'h5A5A, 25'h0AAAAAA, 16'h5A5A};
    beats[0] = 16'h1111; beats[1] = 16'h2222; beats[2] = 16'h3333; beats[3] = 16'h4444;

    reset_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_end_burst = 1'b0;
    sd_bus.sd_ready = 1'b1; sd_bus.sd_data_available = 1'b0; sd_bus.sd_q = '0;

    // Reset state
    repeat (4) step();
    chk("rst_wr_req", 64'(sd_bus.sd_wr_req), 64'd0);
    chk("rst_rd_req", 64'(sd_bus.sd_rd_req), 64'd0);
    chk("rst_end_req", 64'(sd_bus.sd_end_burst_req), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_sd_addr", 64'(sd_bus.sd_addr), 64'd0);
    chk("rst_rd_avail", 64'(rd_data_available), 64'd0);
    reset_n = 1'b1;
    step();

    // Read burst with a trailing beat after end_burst
    expq.push_back('{is_rd: 1'b1, addr: 25'h0001000, data: 16'h0});
    do_rd_req(25'h0001000);
    chk("rd_latency", 64'(sd_bus.sd_rd_req), 64'd1);
    for (int i = 0; i < 4; i++) begin
      sd_bus.sd_data_available = 1'b1;
      sd_bus.sd_q = beats[i];
      rdq.push_back(beats[i]);
      step();
      if (i == 0) chk("rd_beat_latency", 64'(rd_data_available), 64'd1);
    end
    sd_bus.sd_data_available = 1'b0;
    end_burst();
    chk("end_pulse", 64'(sd_bus.sd_end_burst_req), 64'd1);
    sd_bus.sd_data_available = 1'b1;
    sd_bus.sd_q = 16'h5555;
    rdq.push_back(16'h5555);
    step();
    sd_bus.sd_data_available = 1'b0;
    repeat (3) step();
    chk("end_count", 64'(n_end), 64'd1);
    chk("rdq_empty", 64'(rdq.size()), 64'd0);

    // Vector table: single writes pass through unchanged
    for (int i = 0; i < 4; i++) begin
      expq.push_back('{is_rd: 1'b0, addr: vecs[i].exp_addr, data: vecs[i].exp_data});
      do_write(vecs[i].addr, vecs[i].data);
      wait_q(0, 10, "wr_vec_drain");
    end

    // Three writes queued plus a read: read goes first
    sd_bus.sd_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_write(25'h200 + 25'(i), 16'hA000 + 16'(i));
    do_rd_req(25'h0003000);
    repeat (2) step();
    chk("hold_no_req", 64'(expq.size()), 64'd0);
    expq.push_back('{is_rd: 1'b1, addr: 25'h0003000, data: 16'h0});
    for (int i = 0; i < 3; i++) expq.push_back('{is_rd: 1'b0, addr: 25'h200 + 25'(i), data: 16'hA000 + 16'(i)});
    sd_bus.sd_ready = 1'b1;
    wait_q(3, 10, "prio_lo_read");
    repeat (2) step();
    end_burst();
    wait_q(0, 30, "prio_lo_drain");

    // Six writes queued plus a read: one write first, then the read
    sd_bus.sd_ready = 1'b0;
    for (int i = 0; i < 6; i++) do_write(25'h400 + 25'(i), 16'hB000 + 16'(i));
    do_rd_req(25'h0005000);
    expq.push_back('{is_rd: 1'b0, addr: 25'h400, data: 16'hB000});
    expq.push_back('{is_rd: 1'b1, addr: 25'h0005000, data: 16'h0});
    for (int i = 1; i < 6; i++) expq.push_back('{is_rd: 1'b0, addr: 25'h400 + 25'(i), data: 16'hB000 + 16'(i)});
    sd_bus.sd_ready = 1'b1;
    wait_q(5, 10, "prio_hi_read");
    repeat (2) step();
    end_burst();
    wait_q(0, 40, "prio_hi_drain");

    // Writes arriving mid-burst fill the FIFO; the ninth overflows and is dropped
    expq.push_back('{is_rd: 1'b1, addr: 25'h0006000, data: 16'h0});
    do_rd_req(25'h0006000);
    for (int i = 0; i < 8; i++) begin
      expq.push_back('{is_rd: 1'b0, addr: 25'h700 + 25'(i), data: 16'hC000 + 16'(i)});
      do_write(25'h700 + 25'(i), 16'hC000 + 16'(i));
    end
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    chk("pre_overflow", 64'(overflow), 64'd0);
    do_write(25'h07FF, 16'hDEAD);
    chk("overflow_set", 64'(overflow), 64'd1);
    repeat (2) step();
    end_burst();
    wait_q(0, 60, "full_drain");
    repeat (6) step();
    chk("overflow_sticky", 64'(overflow), 64'd1);
    chk("drain_wr_ready", 64'(wr_ready), 64'd1);

`ifdef ARB_STATS_EN
    chk("stat_wr", 64'(stat_wr_grants), 64'(n_wr_seen));
    chk("stat_rd", 64'(stat_rd_bursts), 64'(n_rd_seen));
`endif

    // Reset mid-burst: no end_burst, pending read and queued writes discarded
    expq.push_back('{is_rd: 1'b1, addr: 25'h0123456, data: 16'h0});
    do_rd_req(25'h0123456);
    step();
    do_rd_req(25'h0000777);
    do_write(25'h0000900, 16'h1234);
    do_write(25'h0000901, 16'h5678);
    end_before = n_end;
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("mid_rst_rd_avail", 64'(rd_data_available), 64'd0);
    repeat (10) step();
    chk("mid_rst_no_end", 64'(n_end), 64'(end_before));
    chk("mid_rst_queue", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
